// File: rtl/im_loader.sv
// im_loader -- serial boot loader for the instruction memory.
//
// Receives a little-endian byte stream: a 2-byte word count N, then 4N data
// bytes, then a 4-byte checksum. The checksum is the sum of the N words
// mod 2^32. Each assembled word is written to the instruction memory at
// consecutive word addresses starting at 0. The CPU is held while a
// session is in progress, and also after an aborted session.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   start       single-cycle pulse; begins a session from IDLE/DONE/ERR
//   byte_valid  byte_data carries a byte
//   byte_data   incoming byte
//   byte_ready  loader accepts a byte this cycle (valid & ready = transfer)
//   im_we       instruction-memory write strobe
//   im_addr     instruction-memory word address (PC[11:2] space)
//   im_wdata    instruction word to write
//   cpu_hold    stalls pipeline and PC while loading or after an abort
//   done        last session finished with a matching checksum
//   err         last session aborted (oversize count or bad checksum)
//   word_cnt    words written in the current or last session
//   checksum    running sum of the words written
module im_loader #(
  parameter int DEPTH = 1024  // words; must not exceed 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_we,
  output logic [9:0]  im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] word_cnt,
  output logic [31:0] checksum
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  byte_idx;
  logic [15:0] len_q;
  logic [31:0] field_q;
  logic [31:0] field_cur;
  logic        xfer;
  logic        start_ok;
  logic        field_last;

  assign xfer     = byte_valid && byte_ready;
  assign start_ok = start && ((state == IDLE) || (state == DONE) || (state == ERR));

  // The length field is two bytes; data and checksum fields are four.
  assign field_last = (state == LEN) ? (byte_idx == 2'd1) : (byte_idx == 2'd3);

  // Field value including the byte on the bus this cycle, so decisions on
  // the final byte of a field can be taken without an extra cycle.
  always_comb begin
    field_cur = field_q;
    field_cur[8*byte_idx +: 8] = byte_data;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_nxt = LEN;
      end
      LEN: begin
        if (xfer && field_last) begin
          if (field_cur[15:0] > DEPTH_W)       state_nxt = ERR;
          else if (field_cur[15:0] == 16'd0)   state_nxt = CSUM;
          else                                 state_nxt = DATA;
        end
      end
      DATA: begin
        if (xfer && field_last) state_nxt = WRITE;
      end
      WRITE: begin
        // word_cnt still holds the pre-increment value here.
        if ((word_cnt + 16'd1) == len_q) state_nxt = CSUM;
        else                             state_nxt = DATA;
      end
      CSUM: begin
        if (xfer && field_last) begin
          if (field_cur == checksum) state_nxt = DONE;
          else                       state_nxt = ERR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    byte_ready = (state == LEN) || (state == DATA) || (state == CSUM);
    im_we      = (state == WRITE);
    cpu_hold   = (state != IDLE) && (state != DONE);
    done       = (state == DONE);
    err        = (state == ERR);
  end

  // Session counters and the registered write port. im_addr/im_wdata are
  // loaded only on the last data byte so they stay stable between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= 2'd0;
      len_q    <= 16'd0;
      word_cnt <= 16'd0;
      checksum <= 32'd0;
      im_addr  <= 10'd0;
      im_wdata <= 32'd0;
    end else if (start_ok) begin
      byte_idx <= 2'd0;
      word_cnt <= 16'd0;
      checksum <= 32'd0;
    end else if (xfer) begin
      byte_idx <= field_last ? 2'd0 : byte_idx + 2'd1;
      if ((state == LEN) && field_last) begin
        len_q <= field_cur[15:0];
      end
      if ((state == DATA) && field_last) begin
        im_addr  <= word_cnt[9:0];
        im_wdata <= field_cur;
      end
    end else if (state == WRITE) begin
      word_cnt <= word_cnt + 16'd1;
      checksum <= checksum + im_wdata;
    end
  end

  // Byte assembly; contents are meaningless until a field is complete,
  // so this register carries no reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      field_q[8*byte_idx +: 8] <= byte_data;
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Testbench for im_loader: directed sessions plus randomized sessions with
// random byte gaps, checked against a stream-level reference model.
module tb_im_loader;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        im_we;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] word_cnt;
  logic [31:0] checksum;

  im_loader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err),
    .word_cnt   (word_cnt),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  stream[$];
  logic [41:0] got_wr[$];
  logic [41:0] exp_wr[$];
  logic        exp_done;
  logic        exp_err;
  logic [15:0] exp_cnt;
  logic [31:0] exp_sum;
  int          n_send;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record every write; no byte may be accepted while a write is in flight.
  always @(negedge clk) begin
    if (im_we) begin
      got_wr.push_back({im_addr, im_wdata});
      check("ready_in_write", {31'd0, byte_ready}, 32'd0);
    end
  end

  task automatic push16(input logic [15:0] v);
    stream.push_back(v[7:0]);
    stream.push_back(v[15:8]);
  endtask

  task automatic push32(input logic [31:0] v);
    stream.push_back(v[7:0]);
    stream.push_back(v[15:8]);
    stream.push_back(v[23:16]);
    stream.push_back(v[31:24]);
  endtask

  // Reference model: interpret the byte stream by its format rules.
  task automatic run_model();
    int n;
    logic [31:0] w;
    logic [31:0] rx;
    exp_wr.delete();
    exp_cnt  = 16'd0;
    exp_sum  = 32'd0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = int'(stream[0]) + 256 * int'(stream[1]);
    if (n > DEPTH) begin
      exp_err = 1'b1;
      n_send  = 2;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = {stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]};
      exp_wr.push_back({10'(i), w});
      exp_sum = exp_sum + w;
      exp_cnt = exp_cnt + 16'd1;
    end
    rx = {stream[2+4*n+3], stream[2+4*n+2], stream[2+4*n+1], stream[2+4*n]};
    if (rx == exp_sum) exp_done = 1'b1;
    else               exp_err  = 1'b1;
    n_send = 2 + 4*n + 4;
  endtask

  // Entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int   waited;
    logic accepted;
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    waited     = 0;
    accepted   = 1'b0;
    while (!accepted && waited < 64) begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!accepted) check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
    byte_valid = 1'b0;
  endtask

  task automatic begin_session(input logic byte_with_start);
    got_wr.delete();
    start = 1'b1;
    if (byte_with_start) begin
      byte_valid = 1'b1;
      byte_data  = stream[0];
    end
    @(posedge clk);
    #1;
    start      = 1'b0;
    byte_valid = 1'b0;
    check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
    check("cnt_cleared", {16'd0, word_cnt}, 32'd0);
    check("flags_cleared", {30'd0, done, err}, 32'd0);
  endtask

  // mode: 0 no gaps, 1 gap before every byte, 2 random gaps
  task automatic run_session(input string name, input int mode, input logic byte_with_start);
    int gap;
    run_model();
    begin_session(byte_with_start);
    for (int i = 0; i < n_send; i++) begin
      gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
      send_byte(stream[i], gap);
      if (i < n_send - 1) check({name, "_hold_mid"}, {31'd0, cpu_hold}, 32'd1);
    end
    check({name, "_hold_end"}, {31'd0, cpu_hold}, {31'd0, ~exp_done});
    // Bytes offered after the session must be refused.
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    check({name, "_ready_after"}, {31'd0, byte_ready}, 32'd0);
    check({name, "_done"}, {31'd0, done}, {31'd0, exp_done});
    check({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check({name, "_word_cnt"}, {16'd0, word_cnt}, {16'd0, exp_cnt});
    check({name, "_checksum"}, checksum, exp_sum);
    check({name, "_n_writes"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++) begin
      check({name, "_wr_addr"}, {22'd0, got_wr[i][41:32]}, {22'd0, exp_wr[i][41:32]});
      check({name, "_wr_data"}, got_wr[i][31:0], exp_wr[i][31:0]);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, {31'd0, byte_ready}, 32'd0);
    check({name, "_we"}, {31'd0, im_we}, 32'd0);
    check({name, "_addr"}, {22'd0, im_addr}, 32'd0);
    check({name, "_wdata"}, im_wdata, 32'd0);
    check({name, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({name, "_flags"}, {30'd0, done, err}, 32'd0);
    check({name, "_cnt"}, {16'd0, word_cnt}, 32'd0);
    check({name, "_sum"}, checksum, 32'd0);
  endtask

  task automatic good_stream(input logic [31:0] last);
    stream.delete();
    push16(16'd2);
    push32(32'h12345678);
    push32(32'h00000001);
    push32(last);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic bad;
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("idle_wait");

    // Good load
    good_stream(32'h12345679);
    run_session("good", 0, 1'b0);
    check("good_sum_lit", checksum, 32'h12345679);
    check("good_cnt_lit", {16'd0, word_cnt}, 32'd2);

    // Bad checksum
    good_stream(32'h00000000);
    run_session("badsum", 0, 1'b0);
    check("badsum_err_lit", {31'd0, err}, 32'd1);

    // Oversize count
    stream.delete();
    push16(16'd1025);
    run_session("oversize", 0, 1'b0);

    // Empty load
    stream.delete();
    push16(16'd0);
    push32(32'd0);
    run_session("empty", 0, 1'b0);

    // Stall/backpressure, with a byte offered alongside start
    good_stream(32'h12345679);
    run_session("stall", 1, 1'b1);

    // Mid-session reset after 5 data bytes, then a fresh session
    good_stream(32'h12345679);
    begin_session(1'b0);
    for (int i = 0; i < 7; i++) send_byte(stream[i], 0);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_writes", got_wr.size(), 32'd1);
    check("midrst_idle_hold", {31'd0, cpu_hold}, 32'd0);
    run_session("restart", 0, 1'b0);

    // Randomized sessions
    for (int t = 0; t < 30; t++) begin
      stream.delete();
      if ($urandom_range(0, 9) == 0) begin
        push16(16'($urandom_range(DEPTH + 1, 65535)));
      end else begin
        n   = int'($urandom_range(0, 6));
        bad = ($urandom_range(0, 2) == 0);
        push16(16'(n));
        for (int i = 0; i < n; i++) push32($urandom);
        run_model_sum(n, bad);
      end
      run_session("rand", 2, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Append the checksum field for a stream holding n data words.
  task automatic run_model_sum(input int n, input logic bad);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < n; i++) begin
      s = s + {stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]};
    end
    if (bad) s = s ^ (32'd1 << $urandom_range(0, 31));
    push32(s);
  endtask

endmodule
